// File: rtl/regfile_checkpoint_monitor_if.sv
// Bus between a CPU write-back path / test harness (master) and the checkpoint monitor (slave).
// Carries the write-back snoop, the checkpoint-table configuration, run control and run status.
interface regfile_checkpoint_monitor_if #(
    parameter int NUM_CHECKS = 16,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
);
    logic                  wb_we;
    logic [4:0]            wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  cfg_we;
    logic [IDX_W-1:0]      cfg_idx;
    logic [4:0]            cfg_reg;
    logic [DATA_WIDTH-1:0] cfg_value;
    logic                  start;
    logic [IDX_W:0]        num_checks;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  fail;
    logic                  timeout;
    logic [IDX_W:0]        check_idx;
    logic [DATA_WIDTH-1:0] fail_got;

    modport master (
        output wb_we, wb_addr, wb_data, cfg_we, cfg_idx, cfg_reg, cfg_value, start, num_checks,
        input  busy, done, pass, fail, timeout, check_idx, fail_got
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, cfg_we, cfg_idx, cfg_reg, cfg_value, start, num_checks,
        output busy, done, pass, fail, timeout, check_idx, fail_got
    );
endinterface

// File: rtl/regfile_checkpoint_monitor.sv
// Register-file checkpoint monitor: shadows write-back traffic and checks one register per flag step.
// Define CHECKPOINT_PER_STEP_TIMEOUT_EN to make the timeout a per-checkpoint budget instead of whole-run.
module regfile_checkpoint_monitor #(
    parameter int NUM_CHECKS     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int FLAG_REG       = 20,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input logic                         clk,
    input logic                         rst,
    regfile_checkpoint_monitor_if.slave mon
);
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TBL_DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] shadow_q [32];
    logic [4:0]            tblReg_q [TBL_DEPTH];
    logic [DATA_WIDTH-1:0] tblVal_q [TBL_DEPTH];
    logic [IDX_W:0]        numChecks_q;
    logic [IDX_W:0]        checkIdx_q;
    logic [IDX_W:0]        checkIdx_d;
    logic [CNT_W-1:0]      timer_q;
    logic [CNT_W-1:0]      timerInc;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;
    logic                  fail_q;
    logic                  timeout_q;
    logic [DATA_WIDTH-1:0] failGot_q;

    logic [IDX_W-1:0]      curEntry;
    logic [4:0]            curReg;
    logic [DATA_WIDTH-1:0] observed;
    logic                  flagMatch;
    logic                  expired;

    // The observed value is the post-write view, so a write landing this cycle is forwarded.
    always_comb begin
        curEntry   = checkIdx_q[IDX_W-1:0];
        curReg     = tblReg_q[curEntry];
        checkIdx_d = checkIdx_q + (IDX_W+1)'(1);
        if (curReg == 5'd0) begin
            observed = '0;
        end else if (mon.wb_we && (mon.wb_addr == curReg)) begin
            observed = mon.wb_data;
        end else begin
            observed = shadow_q[curReg];
        end
        flagMatch = (state_q == RUN) && mon.wb_we && (mon.wb_addr == 5'(FLAG_REG))
                    && (mon.wb_data == DATA_WIDTH'(checkIdx_d));
        expired   = (timer_q == CNT_W'(TIMEOUT_CYCLES));
        timerInc  = expired ? timer_q : timer_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (mon.wb_we && (mon.wb_addr != 5'd0)) begin
            shadow_q[mon.wb_addr] <= mon.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                tblReg_q[i] <= '0;
                tblVal_q[i] <= '0;
            end
        end else if (mon.cfg_we && !busy_q) begin
            tblReg_q[mon.cfg_idx] <= mon.cfg_reg;
            tblVal_q[mon.cfg_idx] <= mon.cfg_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            numChecks_q <= '0;
            checkIdx_q  <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            failGot_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (mon.start) begin
                        numChecks_q <= mon.num_checks;
                        checkIdx_q  <= '0;
                        timer_q     <= '0;
                        fail_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        failGot_q   <= '0;
                        if (mon.num_checks == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // A match on the expiry cycle takes priority over the timeout.
                    if (flagMatch) begin
                        if (observed == tblVal_q[curEntry]) begin
                            checkIdx_q <= checkIdx_d;
`ifdef CHECKPOINT_PER_STEP_TIMEOUT_EN
                            timer_q    <= '0;
`else
                            timer_q    <= timerInc;
`endif
                            if (checkIdx_d == numChecks_q) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pass_q  <= 1'b1;
                            end
                        end else begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            fail_q    <= 1'b1;
                            failGot_q <= observed;
                        end
                    end else if (expired) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timerInc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mon.busy      = busy_q;
    assign mon.done      = done_q;
    assign mon.pass      = pass_q;
    assign mon.fail      = fail_q;
    assign mon.timeout   = timeout_q;
    assign mon.check_idx = checkIdx_q;
    assign mon.fail_got  = failGot_q;
endmodule

// File: tb/tb_regfile_checkpoint_monitor.sv
// Scoreboard bench for regfile_checkpoint_monitor: directed test-plan runs plus randomized programs,
// predicted by an op-list reference model and checked by a decoupled monitor process.
module tb_regfile_checkpoint_monitor;
    localparam int NUM_CHECKS     = 16;
    localparam int DATA_WIDTH     = 32;
    localparam int FLAG_REG       = 20;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int IDX_W          = $clog2(NUM_CHECKS);
`ifdef CHECKPOINT_PER_STEP_TIMEOUT_EN
    localparam bit PER_STEP = 1'b1;
`else
    localparam bit PER_STEP = 1'b0;
`endif

    typedef struct {
        bit                  we;
        bit [4:0]            addr;
        bit [DATA_WIDTH-1:0] data;
        bit                  poke;
    } op_t;

    typedef struct {
        bit                  pass;
        bit                  fail;
        bit                  timeout;
        int                  idx;
        bit [DATA_WIDTH-1:0] got;
        int                  doneEdge;
    } exp_t;

    logic clk;
    logic rst;

    regfile_checkpoint_monitor_if #(.NUM_CHECKS(NUM_CHECKS), .DATA_WIDTH(DATA_WIDTH)) bus ();

    regfile_checkpoint_monitor #(
        .NUM_CHECKS    (NUM_CHECKS),
        .DATA_WIDTH    (DATA_WIDTH),
        .FLAG_REG      (FLAG_REG),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(bus)
    );

    op_t                 ops[$];
    exp_t                expQ[$];
    bit [DATA_WIDTH-1:0] mShadow [32];
    bit [4:0]            mReg [NUM_CHECKS];
    bit [DATA_WIDTH-1:0] mVal [NUM_CHECKS];
    int                  checks = 0;
    int                  failures = 0;
    int                  cycleCount = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: replays the run's op list against the spec's rules.
    function automatic exp_t predictRun(input int num, input int s);
        exp_t                e;
        int                  base = 0;
        int                  idx = 0;
        bit                  running;
        bit [DATA_WIDTH-1:0] seen;
        e = '{default: 0};
        running = (num != 0);
        if (!running) begin
            e.pass = 1'b1;
            e.doneEdge = s;
        end
        foreach (ops[j]) begin
            if (ops[j].we && ops[j].addr != 5'd0) mShadow[ops[j].addr] = ops[j].data;
            if (running) begin
                if (ops[j].we && ops[j].addr == 5'(FLAG_REG) && ops[j].data == DATA_WIDTH'(idx + 1)) begin
                    seen = mShadow[mReg[idx]];
                    if (seen == mVal[idx]) begin
                        idx++;
                        if (PER_STEP) base = j + 1;
                        if (idx == num) begin
                            running = 1'b0;
                            e.pass = 1'b1;
                            e.doneEdge = s + 1 + j;
                        end
                    end else begin
                        running = 1'b0;
                        e.fail = 1'b1;
                        e.got = seen;
                        e.doneEdge = s + 1 + j;
                    end
                end else if (j - base >= TIMEOUT_CYCLES) begin
                    running = 1'b0;
                    e.timeout = 1'b1;
                    e.doneEdge = s + 1 + j;
                end
            end
        end
        if (running) begin
            e.timeout = 1'b1;
            e.doneEdge = s + 1 + base + TIMEOUT_CYCLES;
        end
        e.idx = idx;
        return e;
    endfunction

    task automatic idleInputs();
        bus.wb_we = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_reg = '0;
        bus.cfg_value = '0;
        bus.start = 1'b0;
        bus.num_checks = '0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        idleInputs();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) mShadow[i] = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            mReg[i] = '0;
            mVal[i] = '0;
        end
        expQ.delete();
    endtask

    task automatic cfgWrite(input int idx, input int regNum, input bit [DATA_WIDTH-1:0] val);
        @(negedge clk);
        idleInputs();
        bus.cfg_we = 1'b1;
        bus.cfg_idx = IDX_W'(idx);
        bus.cfg_reg = 5'(regNum);
        bus.cfg_value = val;
        mReg[idx] = 5'(regNum);
        mVal[idx] = val;
        @(negedge clk);
        idleInputs();
    endtask

    function automatic void pushW(input int addr, input bit [DATA_WIDTH-1:0] data);
        ops.push_back('{we: 1'b1, addr: 5'(addr), data: data, poke: 1'b0});
    endfunction

    function automatic void pushIdle(input int n);
        for (int i = 0; i < n; i++) ops.push_back('{we: 1'b0, addr: 5'd0, data: '0, poke: 1'b0});
    endfunction

    task automatic waitDone();
        for (int i = 0; i < 2 * TIMEOUT_CYCLES + 200 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput("runFinished", 64'(expQ.size()), 64'd0);
        if (expQ.size() != 0) doReset();
    endtask

    task automatic driveOps();
        foreach (ops[j]) begin
            @(negedge clk);
            idleInputs();
            bus.wb_we = ops[j].we;
            bus.wb_addr = ops[j].addr;
            bus.wb_data = ops[j].data;
            if (ops[j].poke) begin
                bus.start = 1'b1;
                bus.num_checks = (IDX_W+1)'($urandom_range(1, NUM_CHECKS));
                bus.cfg_we = 1'b1;
                bus.cfg_idx = '0;
                bus.cfg_reg = 5'd1;
                bus.cfg_value = $urandom | 32'h1;
            end
        end
        @(negedge clk);
        idleInputs();
    endtask

    // Issues start, pushes the predicted outcome, then drives the op list one op per cycle.
    task automatic applyStimulus(input int num);
        exp_t e;
        @(negedge clk);
        e = predictRun(num, cycleCount + 1);
        expQ.push_back(e);
        idleInputs();
        bus.start = 1'b1;
        bus.num_checks = (IDX_W+1)'(num);
        driveOps();
        waitDone();
    endtask

    task automatic randomRun();
        int num;
        int tgt [NUM_CHECKS];
        bit [DATA_WIDTH-1:0] val [NUM_CHECKS];
        num = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, NUM_CHECKS);
        for (int k = 0; k < num; k++) begin
            int r = $urandom_range(0, 9);
            tgt[k] = (r == 0) ? 0 : (r == 1) ? FLAG_REG : $urandom_range(1, 7);
            val[k] = (tgt[k] == 0) ? '0 : (tgt[k] == FLAG_REG) ? DATA_WIDTH'(k + 1) : $urandom;
            cfgWrite(k, tgt[k], val[k]);
        end
        ops.delete();
        if (num > 0 && $urandom_range(0, 1) == 1) ops.push_back('{we: 1'b0, addr: 5'd0, data: '0, poke: 1'b1});
        for (int k = 0; k < num; k++) begin
            for (int n = $urandom_range(0, 2); n > 0; n--) begin
                case ($urandom_range(0, 3))
                    0: pushW($urandom_range(0, 7), $urandom);
                    1: pushW(FLAG_REG, DATA_WIDTH'($urandom_range(100, 200)));
                    default: pushIdle(1);
                endcase
            end
            if (tgt[k] != 0 && tgt[k] != FLAG_REG)
                pushW(tgt[k], ($urandom_range(0, 9) == 0) ? (val[k] ^ 32'h1) : val[k]);
            pushW(FLAG_REG, DATA_WIDTH'(k + 1));
        end
        pushW($urandom_range(1, 7), $urandom);
        applyStimulus(num);
    endtask

    // Monitor: tracks accepted starts and resets, pops the scoreboard whenever done is presented.
    bit   modelBusy = 1'b0;
    bit   startSeen = 1'b0;
    bit   rstSeen = 1'b0;
    bit   prevDone = 1'b0;
    bit   haveLast = 1'b0;
    exp_t last;

    always begin
        @(posedge clk);
        cycleCount++;
        startSeen = 1'b0;
        rstSeen = 1'b0;
        if (!rst) begin
            modelBusy = 1'b0;
            rstSeen = 1'b1;
        end else if (bus.start && !modelBusy) begin
            startSeen = 1'b1;
            modelBusy = (bus.num_checks != '0);
        end
        @(negedge clk);
        if (rstSeen) begin
            checkOutput("resetStatus", 64'({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout}), 64'd0);
            checkOutput("resetCheckIdx", 64'(bus.check_idx), 64'd0);
            checkOutput("resetFailGot", 64'(bus.fail_got), 64'd0);
            haveLast = 1'b0;
        end else if (bus.done && (!prevDone || startSeen)) begin
            modelBusy = 1'b0;
            if (expQ.size() == 0) begin
                checkOutput("pendingRuns", 64'(expQ.size()), 64'd1);
            end else begin
                last = expQ.pop_front();
                haveLast = 1'b1;
                checkOutput("doneCycle", 64'(cycleCount), 64'(last.doneEdge));
                checkOutput("outcome", 64'({bus.pass, bus.fail, bus.timeout}),
                            64'({last.pass, last.fail, last.timeout}));
                checkOutput("checkIdx", 64'(bus.check_idx), 64'(last.idx));
                checkOutput("failGot", 64'(bus.fail_got), 64'(last.got));
            end
        end else if (bus.done && haveLast) begin
            checkOutput("stickyOutcome", 64'({bus.pass, bus.fail, bus.timeout, bus.check_idx}),
                        64'({last.pass, last.fail, last.timeout, (IDX_W+1)'(last.idx)}));
        end
        if (!rstSeen) checkOutput("busy", 64'(bus.busy), 64'(modelBusy));
        prevDone = bus.done;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got time %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        idleInputs();
        doReset();

        ops.delete();
        applyStimulus(0);

        cfgWrite(0, 1, 300);
        cfgWrite(1, 1, 32'h40);
        cfgWrite(2, 1, 32'hEC);
        ops.delete();
        pushW(1, 300); pushW(FLAG_REG, 1); pushW(1, 32'h40);
        pushW(FLAG_REG, 2); pushW(1, 32'hEC); pushW(FLAG_REG, 3);
        applyStimulus(3);

        ops.delete();
        pushW(1, 300); pushW(FLAG_REG, 1); pushW(1, 32'h41); pushW(FLAG_REG, 2);
        pushW(1, 32'hEC); pushW(FLAG_REG, 3); pushW(FLAG_REG, 1); pushW(1, 32'h55);
        applyStimulus(3);

        cfgWrite(0, 0, 0);
        ops.delete();
        ops.push_back('{we: 1'b1, addr: 5'd0, data: 32'hDEAD_BEEF, poke: 1'b1});
        pushW(FLAG_REG, 5); pushIdle(2); pushW(FLAG_REG, 1);
        applyStimulus(1);

        cfgWrite(0, FLAG_REG, 1);
        ops.delete();
        pushW(FLAG_REG, 1);
        applyStimulus(1);

        ops.delete();
        applyStimulus(1);

        cfgWrite(0, 0, 0);
        cfgWrite(1, 0, 0);
        ops.delete();
        pushIdle(899); pushW(FLAG_REG, 1); pushIdle(899); pushW(FLAG_REG, 2);
        applyStimulus(2);

        cfgWrite(0, 3, 32'h1234);
        @(negedge clk);
        idleInputs();
        bus.start = 1'b1;
        bus.num_checks = (IDX_W+1)'(3);
        ops.delete();
        pushW(3, 32'h1234); pushW(FLAG_REG, 1);
        driveOps();
        doReset();

        ops.delete();
        pushW(FLAG_REG, 1);
        applyStimulus(1);

        for (int r = 0; r < 25; r++) randomRun();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_checkpoint_monitor.md
# regfile_checkpoint_monitor

Synthesizable, parametrised checkpoint monitor for CPU self-test programs. Snoops the register-file write-back port, keeps a shadow copy of the architectural registers, and waits for a flag register to step through checkpoint values 1..N. At each checkpoint it compares one configured register against an expected value. Reports pass, first failure, or timeout. Sits beside `Riscv151` on the write-back path so directed assembly tests are checked on FPGA as well as in simulation.

## Interface
- `NUM_CHECKS`, 16: depth of the checkpoint table (≥1).
- `DATA_WIDTH`, 32: register width.
- `FLAG_REG`, 20: register index used as the checkpoint flag.
- `TIMEOUT_CYCLES`, 1000: cycle budget; counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- `IDX_W`, `$clog2(NUM_CHECKS)`: table index width (derived).

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: synchronous reset, active-low (asserted when 0).
- `wb_we`  in  1: register-file write enable.
- `wb_addr`  in  5: register-file write index.
- `wb_data`  in  DATA_WIDTH: register-file write data.
- `cfg_we`  in  1: table write strobe.
- `cfg_idx`  in  IDX_W: table entry written.
- `cfg_reg`  in  5: register checked at that checkpoint.
- `cfg_value`  in  DATA_WIDTH: expected value.
- `start`  in  1: begin a run. The run uses `num_checks`.
- `num_checks`  in  IDX_W+1: active entries, 0..NUM_CHECKS. Latched on `start`.
- `busy`  out  1: run in progress.
- `done`  out  1: run finished. Sticky until the next accepted `start`.
- `pass` / `fail` / `timeout`  out  1 each: outcome. One-hot when `done`=1.
- `check_idx`  out  IDX_W+1: checkpoints passed so far.
- `fail_got`  out  DATA_WIDTH: observed value at the failing checkpoint.

## Operation
- Shadow file:
  - 32×DATA_WIDTH, updated on every cycle with `wb_we`=1 regardless of state.
  - Writes to index 0 are ignored; entry 0 always reads 0.
- States:
  - IDLE: `start`=1 and `num_checks`=0 → DONE with `pass`=1. `start`=1 otherwise → RUN. Either way `check_idx` is cleared and status is cleared.
  - RUN: a flag match is `wb_we`=1, `wb_addr`=FLAG_REG, and `wb_data`=`check_idx`+1. On a match, compare the shadow value of `cfg_reg[check_idx]` (post-write value, so a target equal to FLAG_REG sees the flag value) against `cfg_value[check_idx]`.
    - Equal: increment `check_idx`. If it reaches the latched count → DONE, `pass`=1.
    - Unequal: → DONE, `fail`=1, `fail_got` = observed value. `check_idx` holds the failing entry index.
    - Flag writes with any other value are ignored.
  - DONE: holds the outcome. `start` restarts the run exactly as from IDLE.
- `start` while `busy` is ignored. `cfg_we` while `busy` is ignored; the table is stable during a run.
- The shadow file is not cleared by `start`, only by `rst`.

## Timing
- Reset values: `busy`, `done`, `pass`, `fail`, `timeout` = 0; `check_idx` = 0; `fail_got` = 0; shadow file = 0; table = 0.
- Start latency: `busy`=1 on the cycle after `start` is sampled.
- Match latency: a flag match sampled at edge k updates `check_idx`, `done`, `pass` and `fail` at edge k, so they are visible in cycle k+1.
- Timeout counter:
  - Cleared on accepted `start`; increments each RUN cycle.
  - When it equals TIMEOUT_CYCLES and there is no match that cycle → DONE, `timeout`=1.
  - A match in the same cycle as expiry wins.
- `rst` asserted mid-run returns to IDLE with all reset values on the next edge.

## Configuration
- `CHECKPOINT_PER_STEP_TIMEOUT_EN` defined: the timeout counter also clears on every passing checkpoint. TIMEOUT_CYCLES is then a per-checkpoint budget.
- Not defined: the counter clears only on `start`. TIMEOUT_CYCLES is then a whole-run budget.

## Test plan
- Full pass:
  - Stimulus: table {0:(x1,300), 1:(x1,0x40), 2:(x1,0xEC)}, `num_checks`=3. Drive x1=300, then x20=1, then x1=0x40, x20=2, then x1=0xEC, x20=3.
  - Response: `pass`=1, `check_idx`=3, `done` one cycle after the last flag write.
- Mismatch:
  - Stimulus: same table. Second checkpoint sees x1=0x41.
  - Response: `fail`=1, `check_idx`=1, `fail_got`=0x41. Later writes cause no change.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=1000, no flag writes.
  - Response: `timeout`=1 exactly 1001 cycles after `busy` rises.
  - With the macro defined and flags spaced 900 cycles apart: `pass`. Without the macro: `timeout` during the second gap.
- Ignored events:
  - Stimulus: write to x0, a flag write with value 5 at `check_idx`=0, `start` and `cfg_we` during RUN.
  - Response: no state change.
- Edge cases:
  - `num_checks`=0 → `pass` on the next cycle.
  - Target register = x20 with expected value 1 → pass.
  - `rst`=0 mid-run → all outputs 0 on the next cycle.
